// File: rtl/alu_datapath.sv
// Single-cycle ALU datapath: control decode, ALU, branch-target adder and output registers.
// Optional signed-overflow detection for R-type ADD/SUB is built when ALU_OVF_EN is defined.
module alu_datapath (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [3:0]  alu_op,
  input  logic [5:0]  funct,
  input  logic [4:0]  branchz_func,
  input  logic [4:0]  shamt,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] pc,
  input  logic [15:0] imm16,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] result,
  output logic        zero,
  output logic [31:0] branch_target,
  output logic        overflow,
  output logic [31:0] result_q,
  output logic        zero_q,
  output logic [31:0] target_q
);

  localparam logic [3:0] CTRL_AND  = 4'd0;
  localparam logic [3:0] CTRL_OR   = 4'd1;
  localparam logic [3:0] CTRL_ADD  = 4'd2;
  localparam logic [3:0] CTRL_XOR  = 4'd3;
  localparam logic [3:0] CTRL_NOR  = 4'd4;
  localparam logic [3:0] CTRL_SLL  = 4'd5;
  localparam logic [3:0] CTRL_SUB  = 4'd6;
  localparam logic [3:0] CTRL_SLT  = 4'd7;
  localparam logic [3:0] CTRL_SLTU = 4'd8;
  localparam logic [3:0] CTRL_SRL  = 4'd9;
  localparam logic [3:0] CTRL_SRA  = 4'd10;
  localparam logic [3:0] CTRL_NE   = 4'd11;
  localparam logic [3:0] CTRL_LTZ  = 4'd12;
  localparam logic [3:0] CTRL_GEZ  = 4'd13;
  localparam logic [3:0] CTRL_LEZ  = 4'd14;
  localparam logic [3:0] CTRL_GTZ  = 4'd15;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_FUNCT  = 4'd2;
  localparam logic [3:0] OP_AND    = 4'd3;
  localparam logic [3:0] OP_OR     = 4'd4;
  localparam logic [3:0] OP_XOR    = 4'd5;
  localparam logic [3:0] OP_SLT    = 4'd6;
  localparam logic [3:0] OP_SLTU   = 4'd7;
  localparam logic [3:0] OP_LUI    = 4'd8;
  localparam logic [3:0] OP_REGIMM = 4'd9;
  localparam logic [3:0] OP_LEZ    = 4'd10;
  localparam logic [3:0] OP_GTZ    = 4'd11;
  localparam logic [3:0] OP_NE     = 4'd12;

  logic [3:0]  funct_ctrl;
  logic [3:0]  regimm_ctrl;
  logic [4:0]  shift_amt;
  logic [31:0] sum_ab;
  logic [32:0] diff_ext;
  logic [31:0] diff_ab;
  logic [31:0] sra_res;
  logic        slt_bit;
  logic        sltu_bit;
  logic        a_neg;
  logic        a_zero;
  logic [31:0] imm_ext;

  always_comb begin
    funct_ctrl = CTRL_ADD;
    case (funct)
      6'h20, 6'h21: funct_ctrl = CTRL_ADD;
      6'h22, 6'h23: funct_ctrl = CTRL_SUB;
      6'h24:        funct_ctrl = CTRL_AND;
      6'h25:        funct_ctrl = CTRL_OR;
      6'h26:        funct_ctrl = CTRL_XOR;
      6'h27:        funct_ctrl = CTRL_NOR;
      6'h2A:        funct_ctrl = CTRL_SLT;
      6'h2B:        funct_ctrl = CTRL_SLTU;
      6'h00, 6'h04: funct_ctrl = CTRL_SLL;
      6'h02, 6'h06: funct_ctrl = CTRL_SRL;
      6'h03, 6'h07: funct_ctrl = CTRL_SRA;
      default:      funct_ctrl = CTRL_ADD;
    endcase
  end

  always_comb begin
    regimm_ctrl = CTRL_ADD;
    case (branchz_func)
      5'h00, 5'h10: regimm_ctrl = CTRL_LTZ;
      5'h01, 5'h11: regimm_ctrl = CTRL_GEZ;
      default:      regimm_ctrl = CTRL_ADD;
    endcase
  end

  // LUI has no code of its own: it reuses the SLL path with a forced amount of 16.
  always_comb begin
    alu_ctrl = CTRL_ADD;
    case (alu_op)
      OP_ADD:    alu_ctrl = CTRL_ADD;
      OP_SUB:    alu_ctrl = CTRL_SUB;
      OP_FUNCT:  alu_ctrl = funct_ctrl;
      OP_AND:    alu_ctrl = CTRL_AND;
      OP_OR:     alu_ctrl = CTRL_OR;
      OP_XOR:    alu_ctrl = CTRL_XOR;
      OP_SLT:    alu_ctrl = CTRL_SLT;
      OP_SLTU:   alu_ctrl = CTRL_SLTU;
      OP_LUI:    alu_ctrl = CTRL_SLL;
      OP_REGIMM: alu_ctrl = regimm_ctrl;
      OP_LEZ:    alu_ctrl = CTRL_LEZ;
      OP_GTZ:    alu_ctrl = CTRL_GTZ;
      OP_NE:     alu_ctrl = CTRL_NE;
      default:   alu_ctrl = CTRL_ADD;
    endcase
  end

  always_comb begin
    shift_amt = shamt;
    if (alu_op == OP_LUI) begin
      shift_amt = 5'd16;
    end else if (funct[2]) begin
      shift_amt = a[4:0];
    end
  end

  assign sum_ab   = a + b;
  assign diff_ext = {1'b0, a} - {1'b0, b};
  assign diff_ab  = diff_ext[31:0];
  assign sra_res  = $signed(b) >>> shift_amt;
  // Signed less-than: differing signs decide directly, otherwise the difference sign does.
  assign slt_bit  = (a[31] != b[31]) ? a[31] : diff_ab[31];
  assign sltu_bit = diff_ext[32];
  assign a_neg    = a[31];
  assign a_zero   = (a == 32'd0);

  // Branch tests return 0 when taken so that zero doubles as the taken flag.
  always_comb begin
    result = sum_ab;
    case (alu_ctrl)
      CTRL_AND:  result = a & b;
      CTRL_OR:   result = a | b;
      CTRL_ADD:  result = sum_ab;
      CTRL_XOR:  result = a ^ b;
      CTRL_NOR:  result = ~(a | b);
      CTRL_SLL:  result = b << shift_amt;
      CTRL_SUB:  result = diff_ab;
      CTRL_SLT:  result = {31'd0, slt_bit};
      CTRL_SLTU: result = {31'd0, sltu_bit};
      CTRL_SRL:  result = b >> shift_amt;
      CTRL_SRA:  result = sra_res;
      CTRL_NE:   result = {31'd0, (a == b)};
      CTRL_LTZ:  result = {31'd0, ~a_neg};
      CTRL_GEZ:  result = {31'd0, a_neg};
      CTRL_LEZ:  result = {31'd0, ~(a_neg | a_zero)};
      CTRL_GTZ:  result = {31'd0, (a_neg | a_zero)};
      default:   result = sum_ab;
    endcase
  end

  assign zero = (result == 32'd0);

  assign imm_ext       = {{14{imm16[15]}}, imm16, 2'b00};
  assign branch_target = pc + 32'd4 + imm_ext;

`ifdef ALU_OVF_EN
  always_comb begin
    overflow = 1'b0;
    if (alu_op == OP_FUNCT) begin
      case (funct)
        6'h20:   overflow = (a[31] == b[31]) && (sum_ab[31] != a[31]);
        6'h22:   overflow = (a[31] != b[31]) && (diff_ab[31] != a[31]);
        default: overflow = 1'b0;
      endcase
    end
  end
`else
  assign overflow = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_q <= 32'd0;
      zero_q   <= 1'b0;
      target_q <= 32'd0;
    end else if (en) begin
      result_q <= result;
      zero_q   <= zero;
      target_q <= branch_target;
    end
  end

endmodule

// File: tb/tb_alu_datapath.sv
// Self-checking bench for alu_datapath: a reference model feeds expected-value queues
// for the combinational outputs and for the registered copies.
module tb_alu_datapath;

  logic        clk;
  logic        reset;
  logic        en;
  logic [3:0]  alu_op;
  logic [5:0]  funct;
  logic [4:0]  branchz_func;
  logic [4:0]  shamt;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] pc;
  logic [15:0] imm16;
  logic [3:0]  alu_ctrl;
  logic [31:0] result;
  logic        zero;
  logic [31:0] branch_target;
  logic        overflow;
  logic [31:0] result_q;
  logic        zero_q;
  logic [31:0] target_q;

  // {ctrl[69:66], result[65:34], zero[33], target[32:1], overflow[0]}
  logic [69:0] exp_q[$];
  // {result[64:33], zero[32], target[31:0]}
  logic [64:0] reg_q[$];

  int n_cmp = 0;
  int n_err = 0;

  alu_datapath dut (
    .clk(clk), .reset(reset), .en(en), .alu_op(alu_op), .funct(funct),
    .branchz_func(branchz_func), .shamt(shamt), .a(a), .b(b), .pc(pc), .imm16(imm16),
    .alu_ctrl(alu_ctrl), .result(result), .zero(zero), .branch_target(branch_target),
    .overflow(overflow), .result_q(result_q), .zero_q(zero_q), .target_q(target_q)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: run did not complete (got running, want finished)");
    $fatal(1);
  end

  function automatic logic [69:0] model(input logic [3:0] op, input logic [5:0] f,
                                        input logic [4:0] bz, input logic [4:0] sh,
                                        input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] p, input logic [15:0] im);
    logic [3:0]  c;
    logic [31:0] r;
    logic [31:0] t;
    logic        o;
    int          amt;
    longint      sx;
    longint      sy;
    longint      s;
    c = 4'd2;
    case (op)
      4'd0: c = 4'd2;
      4'd1: c = 4'd6;
      4'd2: begin
        case (f)
          6'h20, 6'h21: c = 4'd2;
          6'h22, 6'h23: c = 4'd6;
          6'h24: c = 4'd0;
          6'h25: c = 4'd1;
          6'h26: c = 4'd3;
          6'h27: c = 4'd4;
          6'h2A: c = 4'd7;
          6'h2B: c = 4'd8;
          6'h00, 6'h04: c = 4'd5;
          6'h02, 6'h06: c = 4'd9;
          6'h03, 6'h07: c = 4'd10;
          default: c = 4'd2;
        endcase
      end
      4'd3: c = 4'd0;
      4'd4: c = 4'd1;
      4'd5: c = 4'd3;
      4'd6: c = 4'd7;
      4'd7: c = 4'd8;
      4'd8: c = 4'd5;
      4'd9: c = (bz == 5'h00 || bz == 5'h10) ? 4'd12 :
                (bz == 5'h01 || bz == 5'h11) ? 4'd13 : 4'd2;
      4'd10: c = 4'd14;
      4'd11: c = 4'd15;
      4'd12: c = 4'd11;
      default: c = 4'd2;
    endcase
    amt = f[2] ? int'(x[4:0]) : int'(sh);
    case (c)
      4'd0:  r = x & y;
      4'd1:  r = x | y;
      4'd2:  r = x + y;
      4'd3:  r = x ^ y;
      4'd4:  r = ~(x | y);
      4'd5:  r = y << amt;
      4'd6:  r = x - y;
      4'd7:  r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd8:  r = (x < y) ? 32'd1 : 32'd0;
      4'd9:  r = y >> amt;
      4'd10: r = $signed(y) >>> amt;
      4'd11: r = (x != y) ? 32'd0 : 32'd1;
      4'd12: r = ($signed(x) < 0) ? 32'd0 : 32'd1;
      4'd13: r = ($signed(x) >= 0) ? 32'd0 : 32'd1;
      4'd14: r = ($signed(x) <= 0) ? 32'd0 : 32'd1;
      default: r = ($signed(x) > 0) ? 32'd0 : 32'd1;
    endcase
    if (op == 4'd8) r = {y[15:0], 16'h0000};
    t = p + 32'd4 + 32'(int'($signed(im)) * 4);
    o = 1'b0;
`ifdef ALU_OVF_EN
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    s  = (f == 6'h20) ? sx + sy : sx - sy;
    if (op == 4'd2 && (f == 6'h20 || f == 6'h22))
      o = (s > 64'sh7FFF_FFFF) || (s < -64'sh8000_0000);
`else
    sx = 0; sy = 0; s = 0;
`endif
    return {c, r, (r == 32'd0), t, o};
  endfunction

  function automatic logic [69:0] model_cur();
    return model(alu_op, funct, branchz_func, shamt, a, b, pc, imm16);
  endfunction

  // driver
  task automatic apply(input logic [3:0] op, input logic [5:0] f, input logic [4:0] bz,
                       input logic [4:0] sh, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] p, input logic [15:0] im);
    alu_op = op; funct = f; branchz_func = bz; shamt = sh;
    a = x; b = y; pc = p; imm16 = im;
  endtask

  task automatic test_reset();
    logic [64:0] got;
    reset = 1'b0; en = 1'b0;
    apply(4'd0, 6'h20, 5'd0, 5'd0, 32'h1, 32'h2, 32'h100, 16'h4);
    #3;
    got = {result_q, zero_q, target_q};
    n_cmp++;
    if (got !== 65'd0) begin
      n_err++;
      $display("FAIL reset_initial: got %h want 0", got);
    end
    en = 1'b1;
    @(posedge clk); #1;
    got = {result_q, zero_q, target_q};
    n_cmp++;
    if (got !== 65'd0) begin
      n_err++;
      $display("FAIL reset_dominates_en: got %h want 0", got);
    end
    @(negedge clk);
    en = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_spec_vectors();
    logic [69:0] e;
    logic [69:0] got;
    for (int i = 0; i < 10; i++) begin
      case (i)
        0: apply(4'd2, 6'h21, 5'd0, 5'd0, 32'd5, 32'd7, 32'h1000, 16'h0000);
        1: apply(4'd1, 6'h00, 5'd0, 5'd0, 32'h1234, 32'h1234, 32'h1000, 16'h0000);
        2: apply(4'd12, 6'h00, 5'd0, 5'd0, 32'd1, 32'd2, 32'h1000, 16'h0000);
        3: apply(4'd2, 6'h03, 5'd0, 5'd4, 32'd0, 32'h8000_0000, 32'h1000, 16'h0000);
        4: apply(4'd2, 6'h04, 5'd0, 5'd0, 32'd33, 32'd1, 32'h1000, 16'h0000);
        5: apply(4'd0, 6'h00, 5'd0, 5'd0, 32'd0, 32'd0, 32'h1000, 16'hFFFF);
        6: apply(4'd0, 6'h00, 5'd0, 5'd0, 32'd0, 32'd0, 32'h1000, 16'h0001);
        7: apply(4'd9, 6'h00, 5'h00, 5'd0, 32'hFFFF_FFFF, 32'd0, 32'h1000, 16'h0000);
        8: apply(4'd9, 6'h00, 5'h01, 5'd0, 32'hFFFF_FFFF, 32'd0, 32'h1000, 16'h0000);
        default: apply(4'd2, 6'h20, 5'd0, 5'd0, 32'h7FFF_FFFF, 32'd1, 32'h1000, 16'h0000);
      endcase
      exp_q.push_back(model_cur());
      #1;
      got = {alu_ctrl, result, zero, branch_target, overflow};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL spec_vec%0d: got ctrl=%0d res=%h z=%b tgt=%h ovf=%b want ctrl=%0d res=%h z=%b tgt=%h ovf=%b",
                 i, alu_ctrl, result, zero, branch_target, overflow,
                 e[69:66], e[65:34], e[33], e[32:1], e[0]);
      end
      n_cmp++;
      case (i)
        0: if (alu_ctrl !== 4'd2 || result !== 32'd12 || zero !== 1'b0) begin
             n_err++; $display("FAIL addu_const: got ctrl=%0d res=%0d z=%b want 2/12/0", alu_ctrl, result, zero);
           end
        1: if (result !== 32'd0 || zero !== 1'b1) begin
             n_err++; $display("FAIL sub_equal_const: got res=%h z=%b want 0/1", result, zero);
           end
        2: if (zero !== 1'b1) begin
             n_err++; $display("FAIL ne_taken_const: got z=%b want 1", zero);
           end
        3: if (result !== 32'hF800_0000) begin
             n_err++; $display("FAIL sra_const: got %h want f8000000", result);
           end
        4: if (result !== 32'd2) begin
             n_err++; $display("FAIL sllv_const: got %h want 2", result);
           end
        5: if (branch_target !== 32'h1000) begin
             n_err++; $display("FAIL target_back_const: got %h want 1000", branch_target);
           end
        6: if (branch_target !== 32'h1008) begin
             n_err++; $display("FAIL target_fwd_const: got %h want 1008", branch_target);
           end
        7: if (zero !== 1'b1) begin
             n_err++; $display("FAIL bltz_const: got z=%b want 1", zero);
           end
        8: if (zero !== 1'b0) begin
             n_err++; $display("FAIL bgez_const: got z=%b want 0", zero);
           end
        default: begin
`ifdef ALU_OVF_EN
          if (overflow !== 1'b1) begin
            n_err++; $display("FAIL add_ovf_const: got ovf=%b want 1", overflow);
          end
`else
          if (overflow !== 1'b0) begin
            n_err++; $display("FAIL add_ovf_const: got ovf=%b want 0", overflow);
          end
`endif
        end
      endcase
    end
  endtask

  task automatic test_branch_tests();
    logic [69:0] e;
    logic [69:0] got;
    logic [31:0] vals[5];
    logic [3:0]  ops[4];
    vals = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    ops  = '{4'd9, 4'd10, 4'd11, 4'd12};
    for (int o = 0; o < 4; o++) begin
      for (int v = 0; v < 5; v++) begin
        apply(ops[o], 6'h00, (v[0] ? 5'h11 : 5'h10), 5'd0, vals[v], vals[(v + 1) % 5],
              32'hFFFF_FFF0, 16'h0004);
        exp_q.push_back(model_cur());
        #1;
        got = {alu_ctrl, result, zero, branch_target, overflow};
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
          n_err++;
          $display("FAIL branch_op%0d_v%0d: got ctrl=%0d res=%h z=%b tgt=%h want ctrl=%0d res=%h z=%b tgt=%h",
                   ops[o], v, alu_ctrl, result, zero, branch_target,
                   e[69:66], e[65:34], e[33], e[32:1]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [69:0] e;
    logic [69:0] got;
    logic [5:0]  ftab[16];
    logic [31:0] spec_vals[5];
    logic [31:0] x;
    logic [31:0] y;
    logic [5:0]  f;
    ftab = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
             6'h2A, 6'h2B, 6'h00, 6'h04, 6'h02, 6'h06, 6'h03, 6'h07};
    spec_vals = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    for (int i = 0; i < 300; i++) begin
      x = ($urandom_range(0, 2) == 0) ? spec_vals[$urandom_range(0, 4)] : $urandom();
      y = ($urandom_range(0, 2) == 0) ? spec_vals[$urandom_range(0, 4)] : $urandom();
      f = ($urandom_range(0, 3) != 0) ? ftab[$urandom_range(0, 15)] : 6'($urandom_range(0, 63));
      apply(4'($urandom_range(0, 15)), f, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            x, y, $urandom(), 16'($urandom_range(0, 65535)));
      exp_q.push_back(model_cur());
      #1;
      got = {alu_ctrl, result, zero, branch_target, overflow};
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL random%0d op=%0d f=%h: got ctrl=%0d res=%h z=%b tgt=%h ovf=%b want ctrl=%0d res=%h z=%b tgt=%h ovf=%b",
                 i, alu_op, funct, alu_ctrl, result, zero, branch_target, overflow,
                 e[69:66], e[65:34], e[33], e[32:1], e[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [64:0] e;
    logic [64:0] got;
    logic [64:0] last;
    last = 65'd0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      en = (i % 4 != 3);
      apply(4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), $urandom(), $urandom(), $urandom(),
            16'($urandom_range(0, 65535)));
      if (en) last = model_cur()[65:1];
      reg_q.push_back(last);
      @(posedge clk); #1;
      got = {result_q, zero_q, target_q};
      e = reg_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL regs_cycle%0d en=%b: got res=%h z=%b tgt=%h want res=%h z=%b tgt=%h",
                 i, en, result_q, zero_q, target_q, e[64:33], e[32], e[31:0]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [64:0] got;
    logic [64:0] e;
    @(negedge clk);
    en = 1'b1;
    apply(4'd0, 6'h00, 5'd0, 5'd0, 32'd10, 32'd20, 32'h2000, 16'h0010);
    @(posedge clk); #1;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    got = {result_q, zero_q, target_q};
    n_cmp++;
    if (got !== 65'd0) begin
      n_err++;
      $display("FAIL async_reset_no_edge: got %h want 0", got);
    end
    @(negedge clk);
    en = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    got = {result_q, zero_q, target_q};
    n_cmp++;
    if (got !== 65'd0) begin
      n_err++;
      $display("FAIL post_reset_en_low: got %h want 0", got);
    end
    @(negedge clk);
    en = 1'b1;
    apply(4'd8, 6'h00, 5'd0, 5'd0, 32'd0, 32'h0000_ABCD, 32'h3000, 16'hFFFE);
    reg_q.push_back(model_cur()[65:1]);
    @(posedge clk); #1;
    got = {result_q, zero_q, target_q};
    e = reg_q.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("FAIL first_capture: got res=%h z=%b tgt=%h want res=%h z=%b tgt=%h",
               result_q, zero_q, target_q, e[64:33], e[32], e[31:0]);
    end
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_branch_tests();
    test_random();
    test_back_to_back();
    test_async_reset();
    n_cmp++;
    if (exp_q.size() != 0 || reg_q.size() != 0) begin
      n_err++;
      $display("FAIL queues_drained: got %0d/%0d left want 0/0", exp_q.size(), reg_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_datapath.md
ALU_DATAPATH -- requirements
Module: alu_datapath

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clk  in  1  single clock; registered outputs update on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 en  in  1  capture enable for the output registers.
REQ-005 alu_op  in  4  operation class from the control unit.
REQ-006 funct  in  6  instr[5:0], R-type function code.
REQ-007 branchz_func  in  5  instr[20:16], REGIMM selector.
REQ-008 shamt  in  5  instr[10:6], constant shift amount.
REQ-009 a, b  in  32 each  operands; a = rs value, b = rt value or immediate.
REQ-010 pc, imm16  in  32 / 16  current PC and instr[15:0].
REQ-011 alu_ctrl  out  4  decoded ALU operation code.
REQ-012 result  out  32  combinational ALU result.
REQ-013 zero  out  1  combinational flag, 1 when result == 0.
REQ-014 branch_target  out  32  combinational branch address.
REQ-015 overflow  out  1  signed-overflow flag.
REQ-016 result_q / zero_q / target_q  out  32/1/32  registered copies of result, zero and branch_target.

Function
REQ-017 alu_op decode to alu_ctrl:
- 0 -> ADD; 1 -> SUB; 2 -> funct decode; 3 -> AND; 4 -> OR; 5 -> XOR; 6 -> SLT; 7 -> SLTU.
- 8 -> LUI; 9 -> REGIMM decode; 10 -> LEZ; 11 -> GTZ; 12 -> NE.
- 13-15 -> ADD.
REQ-018 alu_ctrl codes: 0 AND, 1 OR, 2 ADD, 3 XOR, 4 NOR, 5 SLL, 6 SUB, 7 SLT, 8 SLTU, 9 SRL, 10 SRA, 11 NE, 12 LTZ, 13 GEZ, 14 LEZ, 15 GTZ.
REQ-019 funct decode:
- 0x20/0x21 ADD; 0x22/0x23 SUB; 0x24 AND; 0x25 OR; 0x26 XOR; 0x27 NOR; 0x2A SLT; 0x2B SLTU.
- 0x00/0x04 SLL; 0x02/0x06 SRL; 0x03/0x07 SRA.
- All other values (including 0x08/0x09) -> ADD.
REQ-020 REGIMM decode: branchz_func 0x00/0x10 -> LTZ; 0x01/0x11 -> GEZ; all other values -> ADD.
REQ-021 Arithmetic and logic ops are modulo 2^32; SLT compares signed; SLTU compares unsigned; both return 32'd1 or 32'd0.
REQ-022 Shifts act on b; amount = a[4:0] when funct[2]=1 (variable form), otherwise shamt; SRA replicates b[31].
REQ-023 LUI: result = {b[15:0], 16'h0000}.
REQ-024 Branch-test codes (NE, LTZ, GEZ, LEZ, GTZ) output 32'd0 when the condition on a (NE compares a with b) is true, otherwise 32'd1, so zero = branch taken.
REQ-025 branch_target = pc + 4 + (sign-extended imm16 << 2), modulo 2^32.
REQ-026 All combinational outputs depend only on current inputs and have no clock latency.
REQ-027 On each rising clk edge with en=1 and reset=1, result_q, zero_q and target_q load the current result, zero and branch_target; with en=0 they hold their values.

Reset
REQ-028 While reset=0, result_q, zero_q and target_q are 0 immediately, independent of clk; reset dominates en.
REQ-029 After reset deasserts, the first capture occurs on the first rising edge with en=1.

Configuration
REQ-030 With macro ALU_OVF_EN defined, overflow = signed two's-complement overflow when alu_op=2 and funct=0x20 (ADD) or funct=0x22 (SUB), and 0 for all other operations; without the macro, overflow is tied to 0 and no overflow logic is built.

Verification
REQ-031 alu_op=2, funct=0x21, a=5, b=7 -> alu_ctrl=2, result=12, zero=0.
REQ-032 alu_op=1, a=b=0x1234 -> result=0, zero=1; alu_op=12, a=1, b=2 -> zero=1.
REQ-033 alu_op=2, funct=0x03, shamt=4, b=0x80000000 -> result=0xF8000000; funct=0x04, a=33, b=1 -> result=2.
REQ-034 pc=0x1000, imm16=0xFFFF -> branch_target=0x1000; imm16=0x0001 -> 0x1008.
REQ-035 alu_op=9, branchz_func=0x00, a=0xFFFFFFFF -> zero=1; branchz_func=0x01, same a -> zero=0.
REQ-036 With ALU_OVF_EN: funct=0x20, a=0x7FFFFFFF, b=1 -> overflow=1. Register check: assert reset mid-run -> result_q=0 without a clock edge; en=0 -> registers hold.
